bcd_display_scanner: RTL

- Consumer end of the 3-digit BCD counter interface (ones/tens/hundred/done).
- Snapshots the three BCD digits on a load strobe and time-multiplexes them onto a common-anode 7-segment display: active-low segments, active-low digit enables.
- Provides leading-zero blanking, a decimal-point flag for counter done, an invalid-digit flag, and a per-frame tick.

---
 rtl/bcd_display_scanner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bcd_display_scanner.sv
// Three-digit BCD scanner for a common-anode 7-segment display.
// Captures digits on load and multiplexes them with leading-zero blanking.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundred,
  input  logic       done,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] an,
  output logic       invalid,
  output logic       frame_tick
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {S_ONES, S_TENS, S_HUND} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_ones;
  logic [3:0]       r_tens;
  logic [3:0]       r_hund;
  logic             r_done_l;

  logic       w_wrap;
  logic [3:0] w_digit;
  logic [2:0] w_an_slot;
  logic       w_zero_blank;
  logic       w_hide;
  logic [6:0] w_seg_code;
  logic       w_bad_capture;
  state_t     w_next_state;

  always_comb begin
    w_wrap        = (r_div == DIV_LAST);
    w_bad_capture = (ones > 4'd9) || (tens > 4'd9) || (hundred > 4'd9);
    w_digit       = r_ones;
    w_an_slot     = 3'b110;
    w_zero_blank  = 1'b0;
    w_next_state  = S_ONES;
    case (r_state)
      S_ONES: begin
        w_digit      = r_ones;
        w_an_slot    = 3'b110;
        w_next_state = S_TENS;
      end
      S_TENS: begin
        w_digit      = r_tens;
        w_an_slot    = 3'b101;
        w_zero_blank = BLANK_LEADING && (r_hund == 4'd0) && (r_tens == 4'd0);
        w_next_state = S_HUND;
      end
      S_HUND: begin
        w_digit      = r_hund;
        w_an_slot    = 3'b011;
        w_zero_blank = BLANK_LEADING && (r_hund == 4'd0);
        w_next_state = S_ONES;
      end
      default: begin
        w_digit      = r_ones;
        w_an_slot    = 3'b111;
        w_next_state = S_ONES;
      end
    endcase
    // Non-BCD shadow digits are hidden exactly like blanked leading zeros.
    w_hide = w_zero_blank || (w_digit > 4'd9);
  end

  always_comb begin
    case (w_digit)
      4'd0:    w_seg_code = 7'h40;
      4'd1:    w_seg_code = 7'h79;
      4'd2:    w_seg_code = 7'h24;
      4'd3:    w_seg_code = 7'h30;
      4'd4:    w_seg_code = 7'h19;
      4'd5:    w_seg_code = 7'h12;
      4'd6:    w_seg_code = 7'h02;
      4'd7:    w_seg_code = 7'h78;
      4'd8:    w_seg_code = 7'h00;
      4'd9:    w_seg_code = 7'h10;
      default: w_seg_code = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_ONES;
      r_div      <= '0;
      r_ones     <= '0;
      r_tens     <= '0;
      r_hund     <= '0;
      r_done_l   <= 1'b0;
      seg        <= '1;
      dp         <= 1'b1;
      an         <= '1;
      invalid    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        r_ones   <= ones;
        r_tens   <= tens;
        r_hund   <= hundred;
        r_done_l <= done;
        if (w_bad_capture) invalid <= 1'b1;
      end

      if (enable) begin
        if (w_wrap) begin
          r_div   <= '0;
          r_state <= w_next_state;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      // Outputs reflect the pre-edge state and shadow, giving one cycle of latency.
      if (!enable || w_hide) begin
        seg <= '1;
        an  <= '1;
      end else begin
        seg <= w_seg_code;
        an  <= w_an_slot;
      end
      dp         <= !(enable && (r_state == S_ONES) && r_done_l);
      frame_tick <= enable && (r_state == S_HUND) && w_wrap;
    end
  end

endmodule
